switch_nibble_capture: RTL and testbench

//  Input stage for the 4-bit operand path: synchronizes four asynchronous board

---
 rtl/input_stage_pkg.sv | 11 +
 rtl/sync_2ff.sv | 23 ++
 rtl/switch_nibble_capture.sv | 118 +++++++++++
 tb/tb_switch_nibble_capture.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_stage_pkg.sv
// rtl/input_stage_pkg.sv - shared FSM encodings and debounce default for the operand input stage
package input_stage_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_DEFAULT = 1000000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            q    <= '0;
        end else begin
            s1_q <= d;
            q    <= s1_q;
        end
    end

endmodule

// File: rtl/switch_nibble_capture.sv
// rtl/switch_nibble_capture.sv - synchronizes and group-debounces the switch nibble into operand A
// Optional committed-change counter port chg_cnt enabled by SW_CHG_COUNT_EN.
module switch_nibble_capture
    import input_stage_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] a_out,
    output logic             a_valid,
    output logic             busy
`ifdef SW_CHG_COUNT_EN
    ,
    output logic [7:0]       chg_cnt
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sw_s;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_out_q, a_out_d;
    logic             a_valid_q, a_valid_d;
    logic             commit;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_in),
        .q   (sw_s)
    );

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        a_out_d   = a_out_q;
        a_valid_d = a_valid_q;
        commit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sw_s != a_out_q) begin
                    state_d = ST_SETTLE;
                    cand_d  = sw_s;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                // Returning to the committed value is a bounce, not a new value.
                if (sw_s == a_out_q) begin
                    state_d = ST_IDLE;
                end else if (sw_s != cand_q) begin
                    cand_d = sw_s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_COMMIT;
                    a_out_d   = cand_q;
                    a_valid_d = 1'b1;
                    commit    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                a_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                a_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            a_out_q   <= '0;
            a_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            a_out_q   <= a_out_d;
            a_valid_q <= a_valid_d;
        end
    end

    assign a_out   = a_out_q;
    assign a_valid = a_valid_q;
    assign busy    = (state_q != ST_IDLE);

`ifdef SW_CHG_COUNT_EN
    logic [7:0] chg_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chg_cnt_q <= '0;
        end else if (commit) begin
            chg_cnt_q <= chg_cnt_q + 8'd1;
        end
    end

    assign chg_cnt = chg_cnt_q;
`else
    logic unused_commit;
    assign unused_commit = commit;
`endif

endmodule

// File: tb/tb_switch_nibble_capture.sv
// tb/tb_switch_nibble_capture.sv - directed self-checking bench for switch_nibble_capture
module tb_switch_nibble_capture;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_in;
    logic [3:0] a_out;
    logic       a_valid;
    logic       busy;
`ifdef SW_CHG_COUNT_EN
    logic [7:0] chg_cnt;
`endif

    int total = 0;
    int bad   = 0;

    switch_nibble_capture #(.WIDTH(4), .DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .a_out   (a_out),
        .a_valid (a_valid),
        .busy    (busy)
`ifdef SW_CHG_COUNT_EN
        ,
        .chg_cnt (chg_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] sw, input int n);
        rst   = 1'b1;
        sw_in = sw;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        sw_in = 4'hA;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (a_out !== 4'h0 || a_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d a_out=%h a_valid=%b busy=%b want 0/0/0", i, a_out, a_valid, busy);
            end
        end
        rst = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            logic       ev;
            logic [3:0] ea;
            tick();
            ev = (i == 10);
            ea = (i >= 10) ? 4'hA : 4'h0;
            total++;
            if (a_valid !== ev || a_out !== ea) begin
                bad++;
                $display("FAIL reset_release edge=E0+%0d a_out=%h a_valid=%b want %h/%b", i, a_out, a_valid, ea, ev);
            end
        end
    endtask

    task automatic test_clean_commit();
        apply_reset(4'h0, 2);
        sw_in = 4'h5;
        for (int i = 0; i <= 12; i++) begin
            logic       eb;
            logic       ev;
            logic [3:0] ea;
            tick();
            eb = (i >= 2 && i <= 10);
            ev = (i == 10);
            ea = (i >= 10) ? 4'h5 : 4'h0;
            total++;
            if (busy !== eb || a_valid !== ev || a_out !== ea) begin
                bad++;
                $display("FAIL clean_commit edge=E0+%0d busy=%b a_valid=%b a_out=%h want %b/%b/%h", i, busy, a_valid, a_out, eb, ev, ea);
            end
        end
    endtask

    task automatic test_bounce();
        logic saw_busy;
        saw_busy = 1'b0;
        apply_reset(4'h0, 2);
        sw_in = 4'h3;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) sw_in = 4'h0;
            tick();
            if (busy === 1'b1) saw_busy = 1'b1;
            total++;
            if (a_out !== 4'h0 || a_valid !== 1'b0) begin
                bad++;
                $display("FAIL bounce edge=E0+%0d a_out=%h a_valid=%b want 0/0", i, a_out, a_valid);
            end
        end
        total++;
        if (saw_busy !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bounce_busy saw_busy=%b busy_end=%b want 1/0", saw_busy, busy);
        end
    endtask

    task automatic test_restart();
        apply_reset(4'h0, 2);
        sw_in = 4'h1;
        for (int i = 0; i <= 18; i++) begin
            logic       ev;
            logic [3:0] ea;
            if (i == 5) sw_in = 4'h9;
            tick();
            ev = (i == 15);
            ea = (i >= 15) ? 4'h9 : 4'h0;
            total++;
            if (a_valid !== ev || a_out !== ea) begin
                bad++;
                $display("FAIL restart edge=E0+%0d a_out=%h a_valid=%b want %h/%b", i, a_out, a_valid, ea, ev);
            end
        end
    endtask

    task automatic test_reset_mid_settle();
        apply_reset(4'h0, 2);
        sw_in = 4'hF;
        repeat (7) tick();
        total++;
        if (busy !== 1'b1 || a_out !== 4'h0) begin
            bad++;
            $display("FAIL mid_settle_pre busy=%b a_out=%h want 1/0", busy, a_out);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (a_out !== 4'h0 || a_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_settle_rst cyc=%0d a_out=%h a_valid=%b busy=%b want 0/0/0", i, a_out, a_valid, busy);
            end
        end
        rst = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            logic       ev;
            logic [3:0] ea;
            tick();
            ev = (i == 10);
            ea = (i >= 10) ? 4'hF : 4'h0;
            total++;
            if (a_valid !== ev || a_out !== ea) begin
                bad++;
                $display("FAIL mid_settle_redo edge=E0+%0d a_out=%h a_valid=%b want %h/%b", i, a_out, a_valid, ea, ev);
            end
        end
    endtask

`ifdef SW_CHG_COUNT_EN
    task automatic test_chg_count();
        apply_reset(4'h0, 2);
        total++;
        if (chg_cnt !== 8'd0) begin
            bad++;
            $display("FAIL chg_cnt_reset chg_cnt=%0d want 0", chg_cnt);
        end
        for (int k = 0; k < 257; k++) begin
            int waited;
            sw_in  = (k % 2 == 0) ? 4'hF : 4'h0;
            waited = 0;
            do begin
                tick();
                waited++;
            end while (a_valid !== 1'b1 && waited < 30);
            if (a_valid !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL chg_cnt_timeout commit=%0d a_valid=%b want 1", k, a_valid);
            end
            if (k == 255) begin
                total++;
                if (chg_cnt !== 8'd0) begin
                    bad++;
                    $display("FAIL chg_cnt_wrap chg_cnt=%0d want 0", chg_cnt);
                end
            end
        end
        total++;
        if (chg_cnt !== 8'd1) begin
            bad++;
            $display("FAIL chg_cnt_final chg_cnt=%0d want 1", chg_cnt);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        sw_in = 4'h0;
        test_reset();
        test_clean_commit();
        test_bounce();
        test_restart();
        test_reset_mid_settle();
`ifdef SW_CHG_COUNT_EN
        test_chg_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
